// File: rtl/fpargmin.sv
// rtl/fpargmin.sv - streaming argmin over IEEE-754 distances with index tracking
// Optional NaN filtering when FPARGMIN_NAN_FILTER_EN is defined.
module fpargmin #(
  parameter int DW = 32,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  input  logic [IW-1:0] in_idx,
  input  logic          in_lst,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic [IW-1:0] out_idx,
  output logic          out_emp
);

  localparam int EW = 8;
  localparam int MW = DW - 1 - EW;

  typedef enum logic {SCAN = 1'b0, HOLD = 1'b1} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_have;
  logic [DW-1:0] r_min_dat;
  logic [IW-1:0] r_min_idx;
  logic [DW-1:0] r_out_dat;
  logic [IW-1:0] r_out_idx;
  logic          w_acc;
  logic          w_qual;
  logic          w_upd;
  logic          w_new_have;
  logic [DW-1:0] w_new_dat;
  logic [IW-1:0] w_new_idx;

  // Map float bits to an unsigned key whose natural order matches float order.
  function automatic logic [DW-1:0] f_key(input logic [DW-1:0] d);
    return d[DW-1] ? ~d : (d | {1'b1, {(DW-1){1'b0}}});
  endfunction

  assign w_acc = in_vld && in_rdy;

`ifdef FPARGMIN_NAN_FILTER_EN
  assign w_qual = !((&in_dat[DW-2:MW]) && (|in_dat[MW-1:0]));
`else
  assign w_qual = 1'b1;
`endif

  assign w_upd      = w_qual && (!r_have || (f_key(in_dat) < f_key(r_min_dat)));
  assign w_new_have = r_have || w_qual;
  assign w_new_dat  = w_upd ? in_dat : r_min_dat;
  assign w_new_idx  = w_upd ? in_idx : r_min_idx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= SCAN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      SCAN: if (w_acc && in_lst) w_next = HOLD;
      HOLD: if (out_rdy)         w_next = SCAN;
      default: w_next = SCAN;
    endcase
  end

  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    if (r_state == SCAN) in_rdy  = 1'b1;
    else                 out_vld = 1'b1;
  end

  // Running minimum folds in every accepted beat; the last beat also snapshots the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_have    <= 1'b0;
      r_min_dat <= '0;
      r_min_idx <= '0;
      r_out_dat <= '0;
      r_out_idx <= '0;
    end else if (w_acc) begin
      r_have    <= w_new_have;
      r_min_dat <= w_new_dat;
      r_min_idx <= w_new_idx;
      if (in_lst) begin
        r_out_dat <= w_new_dat;
        r_out_idx <= w_new_idx;
      end
    end else if (r_state == HOLD && out_rdy) begin
      r_have    <= 1'b0;
      r_min_dat <= '0;
      r_min_idx <= '0;
    end
  end

`ifdef FPARGMIN_NAN_FILTER_EN
  logic r_out_emp;
  always_ff @(posedge clk) begin
    if (rst)                  r_out_emp <= 1'b0;
    else if (w_acc && in_lst) r_out_emp <= !w_new_have;
  end
  assign out_emp = r_out_emp;
`else
  assign out_emp = 1'b0;
`endif

  assign out_dat = r_out_dat;
  assign out_idx = r_out_idx;

endmodule

// File: tb/tb_fpargmin.sv
// tb/tb_fpargmin.sv - directed self-checking bench for fpargmin
module tb_fpargmin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [31:0] in_dat = '0;
  logic [15:0] in_idx = '0;
  logic        in_lst = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [31:0] out_dat;
  logic [15:0] out_idx;
  logic        out_emp;

  int n_vec = 0;
  int n_err = 0;

  fpargmin #(.DW(32), .IW(16)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_idx(in_idx), .in_lst(in_lst),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_idx(out_idx), .out_emp(out_emp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [15:0] i, input logic l);
    in_vld = 1'b1; in_dat = d; in_idx = i; in_lst = l;
    tick();
    in_vld = 1'b0; in_lst = 1'b0;
  endtask

  task automatic release_result();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_vec++; if (in_rdy !== 1'b1)   begin n_err++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    n_vec++; if (out_vld !== 1'b0)  begin n_err++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    n_vec++; if (out_emp !== 1'b0)  begin n_err++; $display("FAIL reset_out_emp got %b want 0", out_emp); end
    n_vec++; if (out_dat !== 32'h0) begin n_err++; $display("FAIL reset_out_dat got %h want 0", out_dat); end
    n_vec++; if (out_idx !== 16'h0) begin n_err++; $display("FAIL reset_out_idx got %h want 0", out_idx); end
  endtask

  task automatic test_basic();
    beat(32'h40400000, 16'd0, 1'b0);
    tick();
    beat(32'h3FC00000, 16'd1, 1'b0);
    beat(32'h40000000, 16'd2, 1'b1);
    n_vec++; if (out_vld !== 1'b1)         begin n_err++; $display("FAIL basic_vld got %b want 1", out_vld); end
    n_vec++; if (in_rdy !== 1'b0)          begin n_err++; $display("FAIL basic_in_rdy got %b want 0", in_rdy); end
    n_vec++; if (out_dat !== 32'h3FC00000) begin n_err++; $display("FAIL basic_dat got %h want 3fc00000", out_dat); end
    n_vec++; if (out_idx !== 16'd1)        begin n_err++; $display("FAIL basic_idx got %0d want 1", out_idx); end
    n_vec++; if (out_emp !== 1'b0)         begin n_err++; $display("FAIL basic_emp got %b want 0", out_emp); end
    release_result();
    n_vec++; if (out_vld !== 1'b0)         begin n_err++; $display("FAIL basic_release_vld got %b want 0", out_vld); end
  endtask

  task automatic test_signed_zero_and_ties();
    beat(32'h00000000, 16'd4, 1'b0);
    beat(32'h80000000, 16'd5, 1'b0);
    beat(32'hBF800000, 16'd6, 1'b1);
    n_vec++; if (out_dat !== 32'hBF800000) begin n_err++; $display("FAIL neg_dat got %h want bf800000", out_dat); end
    n_vec++; if (out_idx !== 16'd6)        begin n_err++; $display("FAIL neg_idx got %0d want 6", out_idx); end
    release_result();
    beat(32'h00000000, 16'd4, 1'b0);
    beat(32'h80000000, 16'd5, 1'b1);
    n_vec++; if (out_idx !== 16'd5)        begin n_err++; $display("FAIL negzero_idx got %0d want 5", out_idx); end
    release_result();
    beat(32'h40000000, 16'd7, 1'b0);
    beat(32'h40000000, 16'd8, 1'b1);
    n_vec++; if (out_idx !== 16'd7)        begin n_err++; $display("FAIL tie_idx got %0d want 7", out_idx); end
    release_result();
    beat(32'h7F800000, 16'd3, 1'b0);
    beat(32'hFF800000, 16'd2, 1'b1);
    n_vec++; if (out_dat !== 32'hFF800000) begin n_err++; $display("FAIL ninf_dat got %h want ff800000", out_dat); end
    release_result();
  endtask

  task automatic test_back_to_back();
    beat(32'h40800000, 16'd3, 1'b1);
    // Next query's only beat is presented while the result is pending.
    in_vld = 1'b1; in_dat = 32'h40E00000; in_idx = 16'd10; in_lst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++; if (in_rdy !== 1'b0 || out_vld !== 1'b1) begin n_err++; $display("FAIL hold_hs[%0d] got rdy=%b vld=%b want 0/1", c, in_rdy, out_vld); end
      n_vec++; if (out_dat !== 32'h40800000 || out_idx !== 16'd3) begin n_err++; $display("FAIL hold_stable[%0d] got %h/%0d want 40800000/3", c, out_dat, out_idx); end
    end
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    n_vec++; if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin n_err++; $display("FAIL release_scan got rdy=%b vld=%b want 1/0", in_rdy, out_vld); end
    tick();
    in_vld = 1'b0; in_lst = 1'b0;
    n_vec++; if (out_vld !== 1'b1)         begin n_err++; $display("FAIL b2b_vld got %b want 1", out_vld); end
    n_vec++; if (out_dat !== 32'h40E00000) begin n_err++; $display("FAIL b2b_dat got %h want 40e00000", out_dat); end
    n_vec++; if (out_idx !== 16'd10)       begin n_err++; $display("FAIL b2b_idx got %0d want 10", out_idx); end
    release_result();
  endtask

  task automatic test_reset_mid();
    beat(32'h3F800000, 16'd0, 1'b0);
    beat(32'h3F000000, 16'd1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst got rdy=%b vld=%b want 1/0", in_rdy, out_vld); end
    beat(32'h40A00000, 16'd9, 1'b1);
    n_vec++; if (out_dat !== 32'h40A00000) begin n_err++; $display("FAIL mid_dat got %h want 40a00000", out_dat); end
    n_vec++; if (out_idx !== 16'd9)        begin n_err++; $display("FAIL mid_idx got %0d want 9", out_idx); end
    // Reset while a result is pending, with every other input active.
    rst = 1'b1; in_vld = 1'b1; in_lst = 1'b1; out_rdy = 1'b1; in_dat = 32'h3F800000; in_idx = 16'd2;
    tick();
    rst = 1'b0; in_vld = 1'b0; in_lst = 1'b0; out_rdy = 1'b0;
    n_vec++; if (out_vld !== 1'b0 || out_dat !== 32'h0 || out_idx !== 16'h0) begin n_err++; $display("FAIL hold_rst got vld=%b dat=%h idx=%0d want 0/0/0", out_vld, out_dat, out_idx); end
    tick();
    n_vec++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin n_err++; $display("FAIL hold_rst_idle got vld=%b rdy=%b want 0/1", out_vld, in_rdy); end
  endtask

  task automatic test_nan();
`ifdef FPARGMIN_NAN_FILTER_EN
    beat(32'h7FC00000, 16'd1, 1'b1);
    n_vec++; if (out_vld !== 1'b1 || out_emp !== 1'b1) begin n_err++; $display("FAIL nan_emp got vld=%b emp=%b want 1/1", out_vld, out_emp); end
    release_result();
    beat(32'h7FC00000, 16'd1, 1'b0);
    beat(32'h3F800000, 16'd2, 1'b1);
    n_vec++; if (out_idx !== 16'd2 || out_emp !== 1'b0) begin n_err++; $display("FAIL nan_skip got idx=%0d emp=%b want 2/0", out_idx, out_emp); end
    release_result();
`else
    beat(32'hFFC00000, 16'd1, 1'b0);
    beat(32'h3F800000, 16'd2, 1'b1);
    n_vec++; if (out_idx !== 16'd1 || out_dat !== 32'hFFC00000) begin n_err++; $display("FAIL nan_order got idx=%0d dat=%h want 1/ffc00000", out_idx, out_dat); end
    n_vec++; if (out_emp !== 1'b0) begin n_err++; $display("FAIL nan_emp got %b want 0", out_emp); end
    release_result();
    beat(32'h3F800000, 16'd3, 1'b0);
    beat(32'h7FC00000, 16'd4, 1'b1);
    n_vec++; if (out_idx !== 16'd3) begin n_err++; $display("FAIL posnan_order got idx=%0d want 3", out_idx); end
    release_result();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_zero_and_ties();
    test_back_to_back();
    test_reset_mid();
    test_nan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
